depuncturer: RTL and testbench
==============================

# depuncturer

Receive-side 802.11a depuncturer: accepts the demapped coded soft-bit stream one bit per beat and re-expands it to rate-1/2 (A,B) pairs, inserting neutral erasures where the transmit encoder stole bits. It sits between the soft demapper and the Viterbi decoder, mirroring the transmit encoder's puncturing for all eight RATE codes.

## Interface
- WIDTH, 3: soft-bit width, signed two's complement; 0 is the neutral erasure value.
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  WIDTH  one coded soft bit.
- s_axis_tvalid / s_axis_tready  in / out  1  input handshake.
- s_axis_tlast  in  1  last coded bit of frame.
- s_axis_tuser  in  4  802.11 RATE field (`RATE_*` codes); sampled only on the first beat of a frame.
- m_axis_tdata  out  2*WIDTH  {B, A}; A in [WIDTH-1:0].
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake.
- m_axis_tlast  out  1  last pair of frame.
- m_axis_tuser  out  2  erasure flags: [0] A erased, [1] B erased.
- rate_err  out  1  one-cycle pulse on an unsupported RATE (see Configuration).

## Operation
- States: IDLE (no frame open), RUN (rate latched), DROP (only with DEPUNCTURER_RATE_CHECK_EN).
- IDLE: first accepted beat latches s_axis_tuser into the rate register, phase=0, then it is processed as a RUN beat. Frame opens in the same cycle.
- Pattern per phase (take A/take B), input order A before B:
  - rate 1/2 (6,12,24M): period 1; phase0 A,B.
  - rate 2/3 (48M): period 2; phase0 A,B; phase1 A only (B erased).
  - rate 3/4 (9,18,36,54M): period 3; phase0 A,B; phase1 A only; phase2 B only (A erased).
- Half register holds captured A until B arrives. A pair completes when every taken component of the current phase is captured; it is then loaded into the output register with erased components = 0 and flags set, and the phase advances modulo period.
- tlast on a pair-completing beat: output tlast=1, return to IDLE, phase=0.
- tlast on an A beat whose phase also takes B: emit the pair immediately with B erased (flag[1]=1), tlast=1, return to IDLE.
- s_axis_tuser is ignored on beats other than the first of the frame.

## Timing
- Single output register; s_axis_tready = aresetn & (!m_axis_tvalid | m_axis_tready). No combinational path from s_axis_tvalid to m_axis_*.
- Latency: pair valid one cycle after the completing input beat is accepted.
- Throughput: one input beat per cycle with m_axis_tready held high; output may be idle on A-only beats.
- m_axis_tvalid holds, and data/user/last stay stable until accepted.
- Async reset: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, rate_err=0, s_axis_tready=0, state IDLE, phase 0, half register cleared. Reset mid-frame discards the partial frame; the next accepted beat after release opens a new frame.

## Configuration
- DEPUNCTURER_RATE_CHECK_EN defined: a first beat whose RATE is not one of the eight valid codes pulses rate_err for one cycle, enters DROP, and consumes and discards beats through tlast with no output. If that first beat has tlast=1, the block stays in IDLE.
- Undefined: unknown codes are treated as rate 1/2; rate_err is tied to 0.

## Structure
- Shared package ieee80211_defs: `RATE_*` codes and coding-rate enum (R12, R23, R34). Rate-to-coding-rate function and pattern constants are added there.
- One natural combinational sub-module, depuncture_pattern: (coding rate, phase) -> take_a, take_b, last_phase.

## Test plan
- 9M, inputs 1,2,3,4 (tlast on 4) -> {A,B,flags}: (1,2,00), (3,0,10), (0,4,01, tlast).
- 6M, inputs 1,2,3,4 -> (1,2,00), (3,4,00, tlast).
- 48M, inputs 5,6,7 (tlast) -> (5,6,00), (7,0,10, tlast); then 54M frame -> pattern restarts at phase0 with the new rate.
- 12M, inputs 1,2,3 (tlast on A) -> (1,2,00), (3,0,10, tlast).
- 9M frame with m_axis_tready low for 5 cycles after the first pair -> s_axis_tready low and output stable, then the full expected sequence with no loss or duplication.
- aresetn pulsed after 2 beats of a 9M frame, then new 6M frame 1,2 -> only (1,2,00, tlast). With the macro defined, RATE 0000 -> rate_err pulse and no output for that frame.

Source files
------------

// File: rtl/ieee80211_defs.sv
// Shared 802.11a definitions: RATE field codes, coding-rate enum, and the
// puncturing pattern tables used by the receive-side depuncturer.
package ieee80211_defs;

    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    typedef enum logic [1:0] {
        R12,
        R23,
        R34
    } code_rate_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DROP
    } dp_state_t;

    // Bit p of each mask says whether phase p keeps that component.
    localparam logic [1:0] TAKE_A_R23 = 2'b11;
    localparam logic [1:0] TAKE_B_R23 = 2'b01;
    localparam logic [3:0] TAKE_A_R34 = 4'b0011;
    localparam logic [3:0] TAKE_B_R34 = 4'b0101;
    localparam logic [1:0] LAST_PHASE_R12 = 2'd0;
    localparam logic [1:0] LAST_PHASE_R23 = 2'd1;
    localparam logic [1:0] LAST_PHASE_R34 = 2'd2;

    function automatic code_rate_t rate_to_code(input logic [3:0] rate);
        case (rate)
            RATE_9M, RATE_18M, RATE_36M, RATE_54M: return R34;
            RATE_48M:                              return R23;
            default:                               return R12;
        endcase
    endfunction

    function automatic logic rate_is_valid(input logic [3:0] rate);
        case (rate)
            RATE_6M, RATE_9M, RATE_12M, RATE_18M,
            RATE_24M, RATE_36M, RATE_48M, RATE_54M: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/depuncture_pattern.sv
// Puncturing pattern lookup: for a coding rate and phase, which of A/B the
// transmitter kept and whether this phase closes the pattern period.
module depuncture_pattern
    import ieee80211_defs::*;
(
    input  logic [1:0] code_rate,
    input  logic [1:0] phase,
    output logic       take_a,
    output logic       take_b,
    output logic       last_phase
);

    always_comb begin
        take_a     = 1'b1;
        take_b     = 1'b1;
        last_phase = (phase == LAST_PHASE_R12);
        case (code_rate_t'(code_rate))
            R23: begin
                take_a     = TAKE_A_R23[phase[0]];
                take_b     = TAKE_B_R23[phase[0]];
                last_phase = (phase == LAST_PHASE_R23);
            end
            R34: begin
                take_a     = TAKE_A_R34[phase];
                take_b     = TAKE_B_R34[phase];
                last_phase = (phase == LAST_PHASE_R34);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/depuncturer.sv
// 802.11a depuncturer: re-expands the coded soft-bit stream to rate-1/2 {B,A}
// pairs with zero erasures. Define DEPUNCTURER_RATE_CHECK_EN to drop frames with bad RATE.
module depuncturer
    import ieee80211_defs::*;
#(
    parameter int WIDTH = 3
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [WIDTH-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    input  logic [3:0]         s_axis_tuser,
    output logic [2*WIDTH-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [1:0]         m_axis_tuser,
    output logic               rate_err
);

    dp_state_t        state_q, state_d;
    code_rate_t       rate_q, rate_d, cur_rate;
    logic [1:0]       phase_q, phase_d, cur_phase;
    logic             a_held_q, a_held_d, cur_held;
    logic [WIDTH-1:0] half_q, half_d;
    logic             accept, first_beat, bad_rate, proc;
    logic             take_a, take_b, last_phase;
    logic             beat_is_a, pair_done;
    logic [WIDTH-1:0] a_val, b_val;

    assign s_axis_tready = aresetn & (~m_axis_tvalid | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign first_beat    = (state_q == ST_IDLE);

    // The first beat of a frame is decoded with the rate it carries, at phase 0.
    assign cur_rate  = first_beat ? rate_to_code(s_axis_tuser) : rate_q;
    assign cur_phase = first_beat ? 2'd0 : phase_q;
    assign cur_held  = first_beat ? 1'b0 : a_held_q;

`ifdef DEPUNCTURER_RATE_CHECK_EN
    assign bad_rate = first_beat & ~rate_is_valid(s_axis_tuser);
`else
    assign bad_rate = 1'b0;
`endif

    assign proc = accept & ~bad_rate & (state_q != ST_DROP);

    depuncture_pattern u_pattern (
        .code_rate  (cur_rate),
        .phase      (cur_phase),
        .take_a     (take_a),
        .take_b     (take_b),
        .last_phase (last_phase)
    );

    // A frame ending on an A beat whose phase also wants B flushes with B erased.
    assign beat_is_a = take_a & ~cur_held;
    assign pair_done = beat_is_a ? (~take_b | s_axis_tlast) : 1'b1;
    assign a_val     = beat_is_a ? s_axis_tdata : (take_a ? half_q : '0);
    assign b_val     = beat_is_a ? '0 : s_axis_tdata;

    always_comb begin
        state_d  = state_q;
        rate_d   = rate_q;
        phase_d  = phase_q;
        a_held_d = a_held_q;
        half_d   = half_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !s_axis_tlast) begin
                    state_d = bad_rate ? ST_DROP : ST_RUN;
                end
            end
            ST_RUN, ST_DROP: begin
                if (accept && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept && first_beat) begin
            rate_d = cur_rate;
        end
        if (proc) begin
            if (pair_done) begin
                a_held_d = 1'b0;
                phase_d  = (last_phase || s_axis_tlast) ? 2'd0 : cur_phase + 2'd1;
            end else begin
                a_held_d = 1'b1;
                half_d   = s_axis_tdata;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            rate_q   <= R12;
            phase_q  <= 2'd0;
            a_held_q <= 1'b0;
            half_q   <= '0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            phase_q  <= phase_d;
            a_held_q <= a_held_d;
            half_q   <= half_d;
        end
    end

    // Single output register; contents only change when the slot is free.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 2'b00;
            m_axis_tlast  <= 1'b0;
        end else if (proc && pair_done) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {b_val, a_val};
            m_axis_tuser  <= {beat_is_a, ~take_a};
            m_axis_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef DEPUNCTURER_RATE_CHECK_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rate_err <= 1'b0;
        end else begin
            rate_err <= accept & bad_rate;
        end
    end
`else
    assign rate_err = 1'b0;
`endif

endmodule

// File: tb/tb_depuncturer.sv
// Table-driven bench for depuncturer: frames per RATE with hand-computed
// {A,B,flags,last} pairs, plus backpressure, reset and bad-RATE sequences.
module tb_depuncturer;
    import ieee80211_defs::*;

    localparam int WIDTH = 3;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic [WIDTH-1:0]   s_axis_tdata = '0;
    logic               s_axis_tvalid = 1'b0;
    logic               s_axis_tready;
    logic               s_axis_tlast = 1'b0;
    logic [3:0]         s_axis_tuser = 4'b0000;
    logic [2*WIDTH-1:0] m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready = 1'b1;
    logic               m_axis_tlast;
    logic [1:0]         m_axis_tuser;
    logic               rate_err;

    int n_compared = 0;
    int n_mismatched = 0;
    int rate_err_cnt = 0;
    logic [8:0] got_q[$];

    typedef struct {
        logic [3:0]       rate;
        int               n_beats;
        logic [3:0][2:0]  din;
        int               n_pairs;
        logic [2:0][8:0]  exp_pairs;
    } vec_t;

    vec_t vecs[8];

    always #5 aclk = ~aclk;

    depuncturer #(.WIDTH(WIDTH)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .rate_err      (rate_err)
    );

    // Inputs change just after posedge, so at negedge a valid&ready pair is a transfer.
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata[5:3], m_axis_tdata[2:0]});
        end
        if (rate_err) rate_err_cnt++;
    end

    function automatic logic [8:0] pr(input logic [2:0] a, input logic [2:0] b,
                                      input logic [1:0] f, input logic l);
        return {l, f, b, a};
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [3:0] rate, input int nb,
                           input logic [3:0][2:0] din, input int np, input logic [2:0][8:0] ex);
        vecs[idx].rate      = rate;
        vecs[idx].n_beats   = nb;
        vecs[idx].din       = din;
        vecs[idx].n_pairs   = np;
        vecs[idx].exp_pairs = ex;
    endtask

    task automatic send_beat(input logic [2:0] d, input logic [3:0] u, input logic l);
        int guard = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready && guard < 50) begin
            guard++;
            @(negedge aclk);
        end
        if (!s_axis_tready) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL send_timeout: got tready=0, expected tready=1");
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Later beats carry a bogus RATE that must be ignored.
    task automatic send_frame(input logic [3:0] rate, input int nb, input logic [3:0][2:0] din);
        for (int b = 0; b < nb; b++) begin
            send_beat(din[b], (b == 0) ? rate : 4'b0000, b == nb - 1);
        end
    endtask

    task automatic check_output(input string name, input int n, input logic [2:0][8:0] ex);
        repeat (4) @(posedge aclk);
        #1;
        check_val({name, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                check_val($sformatf("%s_pair%0d", name, i), 32'(got_q[i]), 32'(ex[i]));
            end
        end
        got_q.delete();
    endtask

    task automatic apply_stimulus(input int idx);
        send_frame(vecs[idx].rate, vecs[idx].n_beats, vecs[idx].din);
        check_output($sformatf("vec%0d", idx), vecs[idx].n_pairs, vecs[idx].exp_pairs);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0][8:0] ex;

        set_vec(0, RATE_9M, 4, {3'd4, 3'd3, 3'd2, 3'd1}, 3,
                {pr(3'd0, 3'd4, 2'b01, 1'b1), pr(3'd3, 3'd0, 2'b10, 1'b0), pr(3'd1, 3'd2, 2'b00, 1'b0)});
        set_vec(1, RATE_6M, 4, {3'd4, 3'd3, 3'd2, 3'd1}, 2,
                {9'd0, pr(3'd3, 3'd4, 2'b00, 1'b1), pr(3'd1, 3'd2, 2'b00, 1'b0)});
        set_vec(2, RATE_48M, 3, {3'd0, 3'd7, 3'd6, 3'd5}, 2,
                {9'd0, pr(3'd7, 3'd0, 2'b10, 1'b1), pr(3'd5, 3'd6, 2'b00, 1'b0)});
        set_vec(3, RATE_54M, 4, {3'd4, 3'd5, 3'd2, 3'd7}, 3,
                {pr(3'd0, 3'd4, 2'b01, 1'b1), pr(3'd5, 3'd0, 2'b10, 1'b0), pr(3'd7, 3'd2, 2'b00, 1'b0)});
        set_vec(4, RATE_12M, 3, {3'd0, 3'd3, 3'd2, 3'd1}, 2,
                {9'd0, pr(3'd3, 3'd0, 2'b10, 1'b1), pr(3'd1, 3'd2, 2'b00, 1'b0)});
        set_vec(5, RATE_18M, 2, {3'd0, 3'd0, 3'd6, 3'd3}, 1,
                {9'd0, 9'd0, pr(3'd3, 3'd6, 2'b00, 1'b1)});
        set_vec(6, RATE_36M, 3, {3'd0, 3'd6, 3'd7, 3'd1}, 2,
                {9'd0, pr(3'd6, 3'd0, 2'b10, 1'b1), pr(3'd1, 3'd7, 2'b00, 1'b0)});
        set_vec(7, RATE_24M, 4, {3'd3, 3'd4, 3'd1, 3'd2}, 2,
                {9'd0, pr(3'd4, 3'd3, 2'b00, 1'b1), pr(3'd2, 3'd1, 2'b00, 1'b0)});

        #2;
        check_val("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        check_val("rst_m_tuser", 32'(m_axis_tuser), 32'd0);
        check_val("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        check_val("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check_val("rst_rate_err", 32'(rate_err), 32'd0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        $display("[TB] directed frame table");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(i);
        end

        $display("[TB] output backpressure on a 9M frame");
        m_axis_tready = 1'b0;
        fork
            send_frame(RATE_9M, 4, {3'd4, 3'd3, 3'd2, 3'd1});
            begin
                int guard = 0;
                @(negedge aclk);
                while (!m_axis_tvalid && guard < 40) begin
                    guard++;
                    @(negedge aclk);
                end
                for (int c = 0; c < 5; c++) begin
                    check_val($sformatf("bp_s_tready%0d", c), 32'(s_axis_tready), 32'd0);
                    check_val($sformatf("bp_m_tvalid%0d", c), 32'(m_axis_tvalid), 32'd1);
                    check_val($sformatf("bp_m_tdata%0d", c), 32'(m_axis_tdata), 32'h11);
                    @(negedge aclk);
                end
                @(posedge aclk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        check_output("bp", 3, vecs[0].exp_pairs);

        $display("[TB] reset in the middle of a 9M frame");
        m_axis_tready = 1'b0;
        send_beat(3'd7, RATE_9M, 1'b0);
        send_beat(3'd6, 4'b0000, 1'b0);
        aresetn = 1'b0;
        #1;
        check_val("midrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("midrst_s_tready", 32'(s_axis_tready), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        got_q.delete();
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        send_frame(RATE_6M, 2, {3'd0, 3'd0, 3'd2, 3'd1});
        ex = {9'd0, 9'd0, pr(3'd1, 3'd2, 2'b00, 1'b1)};
        check_output("after_rst", 1, ex);

        $display("[TB] unknown RATE 0000");
        send_frame(4'b0000, 3, {3'd0, 3'd3, 3'd2, 3'd1});
`ifdef DEPUNCTURER_RATE_CHECK_EN
        check_output("bad_rate", 0, 27'd0);
        check_val("bad_rate_err_cnt", 32'(rate_err_cnt), 32'd1);
`else
        ex = {9'd0, pr(3'd3, 3'd0, 2'b10, 1'b1), pr(3'd1, 3'd2, 2'b00, 1'b0)};
        check_output("bad_rate", 2, ex);
        check_val("bad_rate_err_cnt", 32'(rate_err_cnt), 32'd0);
`endif
        apply_stimulus(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
